fpu_issue_sequencer: RTL and testbench
======================================

# fpu_issue_sequencer

Multi-cycle issue and writeback sequencer for floating-point instructions. It sits between the decode-stage control unit and the iterative FPU datapath. When the control unit flags an FPU instruction (`FPUorALU`), this block captures the operands and launches the FPU. It stalls the pipeline until the result returns, then writes the result to the floating-point or integer register file, following the control unit's `FloatingPointWriteEnable`.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before a watchdog error.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `issue` input 1: the decode stage holds a valid instruction this cycle.
- `FPUorALU` input 1: from the control unit; 1 means an FPU instruction.
- `FloatingPointWriteEnable` input 1: from the control unit; 1 means write the FP register file, 0 means write the integer register file.
- `FPUOpcode` input 4: from the control unit, encoded with the shared FPU opcode constants.
- `op_a`, `op_b` input 32: source operands (fs/rs and ft).
- `dest_addr` input 5: destination register index.
- `stall` output 1: freezes fetch and decode.
- `fpu_start` output 1: one-cycle launch pulse to the FPU.
- `fpu_op` output 4: latched opcode.
- `fpu_a`, `fpu_b` output 32: latched operands.
- `fpu_done` input 1: the FPU result is valid this cycle.
- `fpu_result` input 32: the FPU result.
- `fp_we`, `int_we` output 1: one-cycle register-file write strobes.
- `wb_addr` output 5: write address.
- `wb_data` output 32: write data.
- `fpu_error` output 1: sticky watchdog error flag.

## Operation
- States: IDLE, LAUNCH, WAIT, WRITEBACK, ERROR. Encoding is binary.
- IDLE with `issue & FPUorALU`: on the clock edge, latch `FPUOpcode`, `op_a`, `op_b`, `dest_addr` and `FloatingPointWriteEnable`.
  - For `FPU_MOVE_TO_FLOAT` (which also covers move-from-float), go directly to WRITEBACK with `wb_data = op_a`. This is the bypass path; the FPU is not started.
  - For any other opcode, go to LAUNCH.
- `issue` with `FPUorALU=0` is ignored.
- LAUNCH: `fpu_start=1` for exactly one cycle, then WAIT. Clear the watchdog counter.
- WAIT: hold `fpu_op`, `fpu_a` and `fpu_b` stable.
  - On `fpu_done=1`, latch `fpu_result` into `wb_data` and go to WRITEBACK.
  - Otherwise increment the counter. When the counter equals `TIMEOUT_CYCLES-1` and `fpu_done=0`, go to ERROR.
- WRITEBACK: pulse `fp_we` if the latched `FloatingPointWriteEnable=1`, otherwise pulse `int_we`. `wb_addr` equals the latched `dest_addr`. Return to IDLE.
- ERROR: `fpu_error=1` and `stall=1` until reset. No write strobes are asserted.
- `fpu_done` outside WAIT is ignored, including `fpu_done` coinciding with LAUNCH.
- Reset, asynchronous and possibly mid-operation:
  - State returns to IDLE and the counter to 0.
  - All outputs go to 0: `stall`, `fpu_start`, `fp_we`, `int_we`, `fpu_error`, `wb_addr`, `wb_data`, `fpu_op`, `fpu_a`, `fpu_b`.
  - An in-flight result is discarded.
- Watchdog counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.

## Timing
- `stall` is combinational:
  - 1 in IDLE when `issue & FPUorALU` (the capture cycle).
  - 1 in LAUNCH, WAIT and ERROR.
  - 0 in WRITEBACK, so the pipeline advances on the same edge the write commits.
- Minimum latency from capture edge to write strobe:
  - Bypass path: 1 cycle (WRITEBACK in the next cycle).
  - FPU path: 2 cycles plus the FPU latency (done seen in the first WAIT cycle gives WRITEBACK 3 cycles after capture).
- Write strobes and `fpu_start` are registered and last exactly one cycle.
- Back-to-back operation: a new FPU instruction captured in the IDLE cycle after WRITEBACK has no bubble beyond that IDLE cycle.

## Structure
- The FPU opcode constants (`FPU_ADD`, `FPU_MOVE_TO_FLOAT`, …) and the state enum type belong in the shared opcode package used by the control unit and ALU. Nothing is redefined locally.
- One sub-module is natural: `fpu_watchdog`, a saturating counter with clear, enable and `expired` ports.

## Test plan
- `FPU_ADD`, `op_a=0x3F800000`, `op_b=0x40000000`, `dest_addr=5`, FP write enable=1; FPU model returns `0x40400000` 3 cycles after start:
  - exactly one `fpu_start` pulse;
  - `stall` high from capture through WAIT;
  - one `fp_we` with `wb_addr=5`, `wb_data=0x40400000`;
  - `int_we` stays 0.
- Move-from-float (`FPU_MOVE_TO_FLOAT`, FP write enable=0, `op_a=0xC0490FDB`, `dest_addr=9`):
  - no `fpu_start`;
  - `int_we` pulses one cycle after capture with `wb_data=0xC0490FDB`, `wb_addr=9`.
- `issue=1` with `FPUorALU=0` in IDLE:
  - `stall=0`;
  - no state change and no strobes.
- FPU never asserts done, `TIMEOUT_CYCLES=8`:
  - ERROR entered after 8 WAIT cycles;
  - `fpu_error=1` and `stall=1` persist;
  - a late `fpu_done` produces no write.
- `rst_b` low during WAIT:
  - all outputs go to 0 immediately, without a clock edge;
  - a subsequent `fpu_done` is ignored;
  - a new `FPU_MULT` then completes normally.
- Two FPU instructions back-to-back (done latency 1 cycle):
  - two distinct writebacks with correct addresses and data;
  - no spurious `fpu_start` between them.

Source files
------------

// File: rtl/fpu_issue_sequencer_pkg.sv
// Shared FPU opcode constants, sequencer state type and captured-instruction record.
// Used by the control unit, the ALU and the FPU issue sequencer.
package fpu_issue_sequencer_pkg;

    localparam logic [3:0] FPU_NOP           = 4'd0;
    localparam logic [3:0] FPU_ADD           = 4'd1;
    localparam logic [3:0] FPU_SUB           = 4'd2;
    localparam logic [3:0] FPU_MULT          = 4'd3;
    localparam logic [3:0] FPU_DIV           = 4'd4;
    localparam logic [3:0] FPU_SQRT          = 4'd5;
    localparam logic [3:0] FPU_ABS           = 4'd6;
    localparam logic [3:0] FPU_NEG           = 4'd7;
    localparam logic [3:0] FPU_CVT           = 4'd8;
    localparam logic [3:0] FPU_CMP           = 4'd9;
    localparam logic [3:0] FPU_MOVE_TO_FLOAT = 4'd10;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_LAUNCH    = 3'd1,
        SEQ_WAIT      = 3'd2,
        SEQ_WRITEBACK = 3'd3,
        SEQ_ERROR     = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        fp_we;
    } fpu_instr_t;

    // Register moves in either direction skip the FPU datapath.
    function automatic logic is_bypass(logic [3:0] op);
        return op == FPU_MOVE_TO_FLOAT;
    endfunction

endpackage

// File: rtl/fpu_issue_sequencer_if.sv
// Decode / FPU / register-file bundle of the FPU issue sequencer.
// slave = the sequencer's view, master = the surrounding pipeline's view.
interface fpu_issue_sequencer_if;
    logic        issue;
    logic        FPUorALU;
    logic        FloatingPointWriteEnable;
    logic [3:0]  FPUOpcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest_addr;
    logic        stall;
    logic        fpu_start;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        fp_we;
    logic        int_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fpu_error;

    modport slave (
        input  issue, FPUorALU, FloatingPointWriteEnable, FPUOpcode, op_a, op_b, dest_addr,
        input  fpu_done, fpu_result,
        output stall, fpu_start, fpu_op, fpu_a, fpu_b,
        output fp_we, int_we, wb_addr, wb_data, fpu_error
    );

    modport master (
        output issue, FPUorALU, FloatingPointWriteEnable, FPUOpcode, op_a, op_b, dest_addr,
        output fpu_done, fpu_result,
        input  stall, fpu_start, fpu_op, fpu_a, fpu_b,
        input  fp_we, int_we, wb_addr, wb_data, fpu_error
    );
endinterface

// File: rtl/fpu_issue_sequencer_watchdog.sv
// Saturating WAIT-cycle counter; expired flags the last permitted WAIT cycle.
module fpu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);
endmodule

// File: rtl/fpu_issue_sequencer.sv
// Captures an FPU instruction from decode, launches the iterative FPU, stalls
// the pipeline until the result is back and writes it to the FP or int regfile.
module fpu_issue_sequencer
    import fpu_issue_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_b,
    fpu_issue_sequencer_if.slave  bus
);
    seq_state_e  state_q, state_d;
    fpu_instr_t  instr_q, instr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fpu_start_q, fpu_start_d;
    logic        fp_we_q, fp_we_d;
    logic        int_we_q, int_we_d;
    logic        fpu_error_q, fpu_error_d;
    logic        capture, expired;

    assign capture = bus.issue & bus.FPUorALU;

    fpu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (state_q == SEQ_LAUNCH),
        .en      (state_q == SEQ_WAIT && !bus.fpu_done),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= SEQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:      if (capture) state_d = is_bypass(bus.FPUOpcode) ? SEQ_WRITEBACK : SEQ_LAUNCH;
            SEQ_LAUNCH:    state_d = SEQ_WAIT;
            SEQ_WAIT:      if (bus.fpu_done) state_d = SEQ_WRITEBACK;
                           else if (expired) state_d = SEQ_ERROR;
            SEQ_WRITEBACK: state_d = SEQ_IDLE;
            SEQ_ERROR:     state_d = SEQ_ERROR;
            default:       state_d = SEQ_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered one-cycle pulses.
    always_comb begin
        instr_d   = instr_q;
        wb_data_d = wb_data_q;
        if (state_q == SEQ_IDLE && capture) begin
            instr_d.op    = bus.FPUOpcode;
            instr_d.a     = bus.op_a;
            instr_d.b     = bus.op_b;
            instr_d.dest  = bus.dest_addr;
            instr_d.fp_we = bus.FloatingPointWriteEnable;
            if (is_bypass(bus.FPUOpcode))
                wb_data_d = bus.op_a;
        end
        if (state_q == SEQ_WAIT && bus.fpu_done)
            wb_data_d = bus.fpu_result;
        fpu_start_d = (state_d == SEQ_LAUNCH);
        fp_we_d     = (state_d == SEQ_WRITEBACK) &  instr_d.fp_we;
        int_we_d    = (state_d == SEQ_WRITEBACK) & ~instr_d.fp_we;
        fpu_error_d = (state_d == SEQ_ERROR);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            instr_q     <= '0;
            wb_data_q   <= '0;
            fpu_start_q <= 1'b0;
            fp_we_q     <= 1'b0;
            int_we_q    <= 1'b0;
            fpu_error_q <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            wb_data_q   <= wb_data_d;
            fpu_start_q <= fpu_start_d;
            fp_we_q     <= fp_we_d;
            int_we_q    <= int_we_d;
            fpu_error_q <= fpu_error_d;
        end
    end

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign bus.stall = rst_b & ((state_q == SEQ_IDLE && capture) || state_q == SEQ_LAUNCH ||
                                state_q == SEQ_WAIT || state_q == SEQ_ERROR);

    assign bus.fpu_start = fpu_start_q;
    assign bus.fpu_op    = instr_q.op;
    assign bus.fpu_a     = instr_q.a;
    assign bus.fpu_b     = instr_q.b;
    assign bus.fp_we     = fp_we_q;
    assign bus.int_we    = int_we_q;
    assign bus.wb_addr   = instr_q.dest;
    assign bus.wb_data   = wb_data_q;
    assign bus.fpu_error = fpu_error_q;
endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer: expected writebacks are queued at issue
// and a negedge monitor pops and compares every register-file write strobe.
module tb_fpu_issue_sequencer;
    import fpu_issue_sequencer_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        logic        fp;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    fpu_issue_sequencer_if ifc();

    fpu_issue_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (ifc.slave)
    );

    int errors = 0;
    int checks = 0;
    int n_start = 0, n_fpwe = 0, n_intwe = 0;
    wb_exp_t sb[$];
    wb_exp_t mon_e;

    int          model_lat = 0;
    logic [31:0] model_res = '0;
    int          cnt_m = 0;
    logic        m_done = 1'b0;
    logic        f_done = 1'b0;
    logic [31:0] m_res = '0;

    assign ifc.fpu_done   = m_done | f_done;
    assign ifc.fpu_result = m_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FPU model: done pulses model_lat cycles after the start cycle; 0 = never.
    always @(posedge clk) begin
        #2;
        m_done = 1'b0;
        if (cnt_m > 0) begin
            cnt_m--;
            if (cnt_m == 0) begin
                m_done = 1'b1;
                m_res  = model_res;
            end
        end
        if (ifc.fpu_start && model_lat > 0) cnt_m = model_lat;
    end

    always @(negedge clk) begin
        if (ifc.fpu_start) n_start++;
        if (ifc.fp_we)     n_fpwe++;
        if (ifc.int_we)    n_intwe++;
        if (ifc.fp_we || ifc.int_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'({ifc.fp_we, ifc.int_we}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_strobes", 32'({ifc.fp_we, ifc.int_we}), 32'({mon_e.fp, ~mon_e.fp}));
                chk("wb_addr", 32'(ifc.wb_addr), 32'(mon_e.addr));
                chk("wb_data", ifc.wb_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic fp, input logic [4:0] addr, input logic [31:0] data);
        wb_exp_t e;
        e.fp = fp; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    // Drives one capture cycle; returns one cycle after the capture edge.
    task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, input logic fpwe);
        ifc.issue = 1'b1; ifc.FPUorALU = 1'b1; ifc.FPUOpcode = op;
        ifc.op_a = a; ifc.op_b = b; ifc.dest_addr = d; ifc.FloatingPointWriteEnable = fpwe;
        #1;
        chk("stall_capture", 32'(ifc.stall), 32'd1);
        step();
        ifc.issue = 1'b0; ifc.FPUorALU = 1'b0;
    endtask

    // Steps until a write strobe is visible; n counts cycles since the capture cycle.
    task automatic wait_wb(input int n0, output int n, output bit stall_low);
        n = n0;
        stall_low = 1'b0;
        while (!(ifc.fp_we || ifc.int_we) && n < 40) begin
            if (!ifc.stall) stall_low = 1'b1;
            step();
            n++;
        end
    endtask

    int n, s0, fw0, iw0;
    bit slow;

    initial begin
        ifc.issue = 0; ifc.FPUorALU = 0; ifc.FloatingPointWriteEnable = 0;
        ifc.FPUOpcode = '0; ifc.op_a = '0; ifc.op_b = '0; ifc.dest_addr = '0;
        rst_b = 1'b1;
        #2 rst_b = 1'b0;
        #10;
        chk("rst_flags", 32'({ifc.stall, ifc.fpu_start, ifc.fp_we, ifc.int_we, ifc.fpu_error}), 32'd0);
        chk("rst_wb", 32'(ifc.wb_addr) | ifc.wb_data, 32'd0);
        chk("rst_fpu_regs", 32'(ifc.fpu_op) | ifc.fpu_a | ifc.fpu_b, 32'd0);
        step();
        rst_b = 1'b1;
        step();

        // FP add through the FPU, result 3 cycles after start
        model_lat = 3; model_res = 32'h40400000;
        s0 = n_start; fw0 = n_fpwe; iw0 = n_intwe;
        expect_wb(1'b1, 5'd5, 32'h40400000);
        issue_op(FPU_ADD, 32'h3F800000, 32'h40000000, 5'd5, 1'b1);
        chk("add_start_pulse", 32'(ifc.fpu_start), 32'd1);
        step();
        chk("add_hold_op", 32'(ifc.fpu_op), 32'(FPU_ADD));
        chk("add_hold_a", ifc.fpu_a, 32'h3F800000);
        chk("add_hold_b", ifc.fpu_b, 32'h40000000);
        wait_wb(2, n, slow);
        chk("add_latency", 32'(n), 32'd5);
        chk("add_stall_held", 32'(slow), 32'd0);
        chk("add_stall_wb", 32'(ifc.stall), 32'd0);
        step();
        chk("add_starts", 32'(n_start - s0), 32'd1);
        chk("add_fpwe_cnt", 32'(n_fpwe - fw0), 32'd1);
        chk("add_intwe_cnt", 32'(n_intwe - iw0), 32'd0);

        // Move-from-float bypass
        s0 = n_start; iw0 = n_intwe;
        expect_wb(1'b0, 5'd9, 32'hC0490FDB);
        issue_op(FPU_MOVE_TO_FLOAT, 32'hC0490FDB, 32'h0, 5'd9, 1'b0);
        wait_wb(1, n, slow);
        chk("mov_latency", 32'(n), 32'd1);
        chk("mov_stall_wb", 32'(ifc.stall), 32'd0);
        step();
        chk("mov_starts", 32'(n_start - s0), 32'd0);
        chk("mov_intwe_cnt", 32'(n_intwe - iw0), 32'd1);

        // Non-FPU issue is ignored
        s0 = n_start; fw0 = n_fpwe; iw0 = n_intwe;
        ifc.issue = 1'b1; ifc.FPUorALU = 1'b0; ifc.FPUOpcode = FPU_ADD;
        #1;
        chk("alu_stall", 32'(ifc.stall), 32'd0);
        repeat (3) step();
        chk("alu_stall_later", 32'(ifc.stall), 32'd0);
        chk("alu_no_activity", 32'((n_start - s0) + (n_fpwe - fw0) + (n_intwe - iw0)), 32'd0);
        ifc.issue = 1'b0;
        step();

        // Watchdog: FPU never responds
        model_lat = 0;
        fw0 = n_fpwe; iw0 = n_intwe;
        issue_op(FPU_DIV, 32'h1, 32'h2, 5'd4, 1'b1);
        n = 1;
        while (!ifc.fpu_error && n < 40) begin
            step();
            n++;
        end
        chk("wd_error_cycle", 32'(n), 32'd10);
        chk("wd_stall", 32'(ifc.stall), 32'd1);
        f_done = 1'b1;
        step();
        f_done = 1'b0;
        repeat (4) step();
        chk("wd_error_sticky", 32'({ifc.fpu_error, ifc.stall}), 32'd3);
        chk("wd_late_done_no_write", 32'((n_fpwe - fw0) + (n_intwe - iw0)), 32'd0);
        #1 rst_b = 1'b0;
        #1;
        chk("wd_reset_clears", 32'({ifc.fpu_error, ifc.stall}), 32'd0);
        step();
        rst_b = 1'b1;
        step();

        // Reset while waiting on the FPU
        issue_op(FPU_SUB, 32'h11111111, 32'h22222222, 5'd17, 1'b0);
        step();
        step();
        chk("rw_pre_op", 32'(ifc.fpu_op), 32'(FPU_SUB));
        #2 rst_b = 1'b0;
        #1;
        chk("rw_flags", 32'({ifc.stall, ifc.fpu_start, ifc.fp_we, ifc.int_we, ifc.fpu_error}), 32'd0);
        chk("rw_wb_addr", 32'(ifc.wb_addr), 32'd0);
        chk("rw_wb_data", ifc.wb_data, 32'd0);
        chk("rw_fpu_op", 32'(ifc.fpu_op), 32'd0);
        chk("rw_fpu_ab", ifc.fpu_a | ifc.fpu_b, 32'd0);
        step();
        rst_b = 1'b1;
        s0 = n_start; fw0 = n_fpwe; iw0 = n_intwe;
        f_done = 1'b1;
        step();
        f_done = 1'b0;
        repeat (2) step();
        chk("rw_done_ignored", 32'((n_fpwe - fw0) + (n_intwe - iw0) + (n_start - s0)), 32'd0);
        chk("rw_stall_idle", 32'(ifc.stall), 32'd0);
        model_lat = 2; model_res = 32'h40C00000;
        expect_wb(1'b1, 5'd12, 32'h40C00000);
        issue_op(FPU_MULT, 32'h40000000, 32'h40400000, 5'd12, 1'b1);
        wait_wb(1, n, slow);
        chk("mult_latency", 32'(n), 32'd4);
        step();
        chk("mult_starts", 32'(n_start - s0), 32'd1);

        // Back-to-back FPU ops, done latency 1
        model_lat = 1; model_res = 32'h40800000;
        s0 = n_start;
        expect_wb(1'b1, 5'd3, 32'h40800000);
        issue_op(FPU_ADD, 32'h40000000, 32'h40000000, 5'd3, 1'b1);
        wait_wb(1, n, slow);
        chk("b2b_first_latency", 32'(n), 32'd3);
        step();
        model_res = 32'h3F800000;
        expect_wb(1'b0, 5'd7, 32'h3F800000);
        issue_op(FPU_SUB, 32'h40800000, 32'h40400000, 5'd7, 1'b0);
        wait_wb(1, n, slow);
        chk("b2b_second_latency", 32'(n), 32'd3);
        step();
        chk("b2b_starts", 32'(n_start - s0), 32'd2);

        repeat (2) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
